apb_transfer_ctrl: RTL and testbench
====================================

// Module: apb_transfer_ctrl
// PURPOSE
//  Sequences APB transfers for the AHB-to-APB bridge. Accepts single read/write requests from the
//  AHB slave side, decodes the target peripheral, and drives APB SETUP/ACCESS phases into
//  apb_interface. Returns read data and error status on a one-cycle response pulse.
//  Holds a one-deep request buffer so the AHB side can queue the next transfer during the current one.
// PARAMETERS
//  ADDR_W    32  address width
//  DATA_W    32  data width
//  TIMEOUT   16  max ACCESS cycles with pready=0 before abort (>=2)
// PORTS
//  hclk       in   1       clock; all logic rising-edge
//  hresetn    in   1       asynchronous active-low reset
//  req_valid  in   1       request offered
//  req_write  in   1       1=write, 0=read
//  req_addr   in   ADDR_W  request address
//  req_wdata  in   DATA_W  write data
//  req_ready  out  1       buffer free; accept when req_valid&&req_ready
//  rsp_valid  out  1       one-cycle completion pulse
//  rsp_err    out  1       qualifies rsp_valid: unmapped address or timeout
//  rsp_rdata  out  DATA_W  read data (0 for writes/errors), valid with rsp_valid
//  pready     in   1       APB slave ready (tie 1 for zero-wait slaves)
//  prdata     in   DATA_W  APB read data
//  pwrite     out  1       APB write
//  penable    out  1       APB enable
//  pselx      out  3       one-hot APB select
//  paddr      out  ADDR_W  APB address
//  pwdata     out  DATA_W  APB write data
// BEHAVIOUR
//  Reset: all outputs 0 except req_ready=1; state IDLE; buffer empty; timeout counter 0.
//  Reset mid-transfer: immediate abort; buffered request dropped; no rsp pulse.
//  Buffer: loaded on accept; req_ready = !buf_valid (registered, no combinational path from pready).
//  Consume: buffer emptied when FSM takes it (IDLE, or ACCESS completing); a new accept may occur next cycle.
//  Decode, 64 MB windows: 0x8000_0000-0x83FF_FFFF->3'b001, 0x8400_0000-0x87FF_FFFF->3'b010,
//   0x8800_0000-0x8BFF_FFFF->3'b100; any other address is a miss.
//  FSM states: IDLE, SETUP, ACCESS, RESP_ERR.
//   IDLE: buf_valid & hit -> SETUP; buf_valid & miss -> RESP_ERR; else IDLE.
//   SETUP (1 cycle): pselx=decode, penable=0, paddr/pwdata/pwrite from request -> ACCESS.
//   ACCESS: penable=1, other APB outputs stable. Completes when pready=1.
//    After completion: buf_valid & hit -> SETUP (no IDLE bubble); buf_valid & miss -> RESP_ERR; else IDLE.
//   RESP_ERR (1 cycle): no APB activity -> IDLE (or SETUP if a hit request is buffered).
//  Timeout: the counter increments each ACCESS cycle with pready=0 and clears on entry to SETUP.
//   When it reaches TIMEOUT-1 with pready=0, abort: next cycle pselx=0, penable=0, rsp_err=1.
//  Response: rsp_valid pulses exactly one cycle after ACCESS completion, abort, or RESP_ERR.
//   rsp_rdata = prdata sampled at completion for reads; 0 otherwise.
//  Latency (zero-wait): accept edge N; SETUP N+1; ACCESS N+2; rsp_valid N+3.
//   Back-to-back: 2 cycles per transfer.
//  APB outputs registered. Outside SETUP/ACCESS: pselx=0, penable=0; paddr/pwdata/pwrite hold last values.
// STRUCTURE
//  apb_bridge_pkg: state encoding, window base/size constants, PSEL width, decode function.
//  Sub-module apb_addr_decode: combinational addr -> {hit, pselx}. Instanced once, on the buffer output.
//  Top: buffer, FSM, timeout counter, response registers.
// TESTING
//  1 Write 0x8000_0010 / 0xDEAD_BEEF, pready=1 -> SETUP pselx=001 penable=0; ACCESS penable=1;
//    rsp_valid one cycle later with rsp_err=0, rsp_rdata=0.
//  2 Read 0x8400_0004, prdata=0x0000_00A5 -> pselx=010, pwrite=0; rsp_rdata=0x0000_00A5, rsp_err=0.
//  3 Back-to-back: writes to 0x8800_0000 and 0x8000_0000 offered consecutively ->
//    SETUP,ACCESS,SETUP,ACCESS with no IDLE gap; req_ready low while buffer is full; two rsp pulses.
//  4 Unmapped 0x9000_0000 -> pselx stays 0, penable stays 0; rsp_valid=1, rsp_err=1 two cycles after accept.
//  5 pready held 0, TIMEOUT=16 -> 16 ACCESS cycles, then pselx=0, penable=0, rsp_err=1.
//    pready=0 for 3 cycles -> normal completion.
//  6 Assert hresetn=0 during ACCESS with a request buffered -> all outputs 0 and req_ready=1 immediately;
//    no rsp_valid after release.

Source files
------------

// File: rtl/apb_bridge_pkg.sv
// Shared state encoding, APB select width and peripheral address map
// for the AHB-to-APB transfer controller.
package apb_bridge_pkg;

    localparam int          PSEL_W   = 3;
    localparam logic [63:0] WIN_BASE = 64'h8000_0000;
    localparam logic [63:0] WIN_SIZE = 64'h0400_0000;  // 64 MB per peripheral, windows are contiguous

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP_ERR
    } state_t;

    typedef struct packed {
        logic              hit;
        logic [PSEL_W-1:0] sel;
    } decode_t;

    // Window i selects psel bit i; anything outside all windows is a miss.
    function automatic decode_t addr_decode(input logic [63:0] addr);
        decode_t d;
        d = '0;
        for (int i = 0; i < PSEL_W; i++) begin
            if (addr >= WIN_BASE + WIN_SIZE * 64'(i) && addr < WIN_BASE + WIN_SIZE * 64'(i + 1)) begin
                d.hit    = 1'b1;
                d.sel[i] = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational peripheral decode: address -> {hit, one-hot APB select}.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic              hit_o,
    output logic [PSEL_W-1:0] sel_o
);

    decode_t dec;

    always_comb begin
        dec   = addr_decode(64'(addr_i));
        hit_o = dec.hit;
        sel_o = dec.sel;
    end

endmodule

// File: rtl/apb_transfer_ctrl.sv
// APB transfer sequencer: one-deep request buffer, SETUP/ACCESS FSM with
// wait-state timeout, and a registered one-cycle response pulse.
module apb_transfer_ctrl
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    input  logic              pready,
    input  logic [DATA_W-1:0] prdata,
    output logic              pwrite,
    output logic              penable,
    output logic [PSEL_W-1:0] pselx,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata
);

    localparam int CNT_W = $clog2(TIMEOUT);

    logic              buf_valid_q, buf_write_q;
    logic [ADDR_W-1:0] buf_addr_q;
    logic [DATA_W-1:0] buf_wdata_q;
    logic              buf_hit;
    logic [PSEL_W-1:0] buf_sel;
    logic              accept, take;

    state_t            state_q, state_d, disp_state;
    logic [CNT_W-1:0]  tmo_q, tmo_d;
    logic              access_done, access_abort;

    logic [PSEL_W-1:0] psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

    apb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .addr_i (buf_addr_q),
        .hit_o  (buf_hit),
        .sel_o  (buf_sel)
    );

    // Accept only into an empty buffer and take only from a full one, so both never coincide.
    assign accept = req_valid && !buf_valid_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            buf_valid_q <= 1'b0;
            buf_write_q <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
        end else if (accept) begin
            buf_valid_q <= 1'b1;
            buf_write_q <= req_write;
            buf_addr_q  <= req_addr;
            buf_wdata_q <= req_wdata;
        end else if (take) begin
            buf_valid_q <= 1'b0;
        end
    end

    assign access_done  = (state_q == ST_ACCESS) && pready;
    assign access_abort = (state_q == ST_ACCESS) && !pready && (tmo_q == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= ST_IDLE;
            tmo_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_q       <= tmo_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Wherever the FSM is free to start work it dispatches straight from the buffer.
    always_comb begin
        disp_state = ST_IDLE;
        if (buf_valid_q) disp_state = buf_hit ? ST_SETUP : ST_RESP_ERR;
        state_d = state_q;
        take    = 1'b0;
        case (state_q)
            ST_SETUP: state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (access_abort) begin
                    state_d = ST_IDLE;
                end else if (access_done) begin
                    state_d = disp_state;
                    take    = buf_valid_q;
                end
            end
            default: begin
                state_d = disp_state;
                take    = buf_valid_q;
            end
        endcase
        tmo_d = tmo_q;
        if (state_d == ST_SETUP) tmo_d = '0;
        else if (state_q == ST_ACCESS && !pready && !access_abort) tmo_d = tmo_q + 1'b1;
    end

    always_comb begin
        psel_d    = '0;
        penable_d = 1'b0;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        case (state_d)
            ST_SETUP: begin
                psel_d   = buf_sel;
                pwrite_d = buf_write_q;
                paddr_d  = buf_addr_q;
                pwdata_d = buf_wdata_q;
            end
            ST_ACCESS: begin
                psel_d    = psel_q;
                penable_d = 1'b1;
            end
            default: ;
        endcase
        rsp_valid_d = access_done || access_abort || (state_q == ST_RESP_ERR);
        rsp_err_d   = access_abort || (state_q == ST_RESP_ERR);
        rsp_rdata_d = (access_done && !pwrite_q) ? prdata : '0;
    end

    assign req_ready = !buf_valid_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign pselx     = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;

endmodule

// File: tb/tb_apb_transfer_ctrl.sv
// Bench for apb_transfer_ctrl: directed vector table, hand-built multi-cycle
// sequences, and a randomized run against a transaction-level reference model.
module tb_apb_transfer_ctrl;

    logic        hclk, hresetn;
    logic        req_valid, req_write, req_ready;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        pready, pwrite, penable;
    logic [31:0] prdata, paddr, pwdata;
    logic [2:0]  pselx;

    apb_transfer_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
        .pready(pready), .prdata(prdata),
        .pwrite(pwrite), .penable(penable), .pselx(pselx), .paddr(paddr), .pwdata(pwdata)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic        write;
        logic [31:0] addr, wdata, prdata;
        int          waits;
        logic [2:0]  sel;
        logic        err;
        logic [31:0] rdata;
    } vec_t;

    typedef struct {
        logic        write;
        logic [31:0] addr, wdata;
    } req_t;

    localparam int NRAND = 200;

    int          n_chk = 0, n_pass = 0;
    vec_t        vecs [10];
    req_t        exp_q [$];
    logic [31:0] bnd [8];
    logic [2:0]  bb_sel [6];
    logic [2:0]  bb_flags [6];  // {penable, req_ready, rsp_valid}

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic smp();
        @(negedge hclk);
    endtask

    // Address map straight from the window table: 64 MB windows from 0x8000_0000.
    function automatic logic [2:0] ref_sel(input logic [31:0] a);
        if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
        return 3'b001 << ((a - 32'h8000_0000) >> 26);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 32'h8000_0000 | (r & 32'h03FF_FFFF);
            1:       return 32'h8400_0000 | (r & 32'h03FF_FFFF);
            2:       return 32'h8800_0000 | (r & 32'h03FF_FFFF);
            3:       return r;
            4:       return bnd[$urandom_range(0, 7)];
            default: return 32'h9000_0000 | (r & 32'h0FFF_FFFF);
        endcase
    endfunction

    // Single isolated transfer with cycle-exact expectations.
    task automatic run_vec(input int idx, input vec_t v);
        tick();
        req_valid = 1'b1; req_write = v.write; req_addr = v.addr; req_wdata = v.wdata;
        prdata = v.prdata; pready = (v.waits == 0);
        smp(); chk($sformatf("vec%0d/ready", idx), 64'(req_ready), 64'(1));
        tick(); req_valid = 1'b0;
        smp(); chk($sformatf("vec%0d/buffered", idx), 64'({req_ready, pselx, penable, rsp_valid}), 64'(0));
        tick(); smp();
        if (v.err) begin
            chk($sformatf("vec%0d/err_gap", idx), 64'({pselx, penable, rsp_valid}), 64'(0));
            tick(); smp();
            chk($sformatf("vec%0d/err_rsp", idx), 64'({pselx, penable, rsp_valid, rsp_err, rsp_rdata}),
                64'({3'b000, 1'b0, 1'b1, 1'b1, 32'h0}));
        end else begin
            chk($sformatf("vec%0d/setup", idx), 64'({pselx, penable, pwrite, paddr}), 64'({v.sel, 1'b0, v.write, v.addr}));
            if (v.write) chk($sformatf("vec%0d/pwdata", idx), 64'(pwdata), 64'(v.wdata));
            for (int k = 0; k <= v.waits; k++) begin
                tick(); pready = (k == v.waits); smp();
                chk($sformatf("vec%0d/access%0d", idx, k), 64'({pselx, penable, rsp_valid}), 64'({v.sel, 1'b1, 1'b0}));
            end
            tick(); pready = 1'b1; smp();
            chk($sformatf("vec%0d/rsp", idx), 64'({pselx, penable, rsp_valid, rsp_err, rsp_rdata}),
                64'({3'b000, 1'b0, 1'b1, 1'b0, v.rdata}));
        end
        tick(); smp();
        chk($sformatf("vec%0d/quiet", idx), 64'({rsp_valid, req_ready}), 64'(2'b01));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "/ctl"}, 64'({req_ready, rsp_valid, rsp_err, pwrite, penable, pselx}), 64'({1'b1, 7'b0}));
        chk({nm, "/addr_rdata"}, {paddr, rsp_rdata}, 64'(0));
        chk({nm, "/pwdata"}, 64'(pwdata), 64'(0));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached, summary %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int     n_sent, zrun, cnt;
        bit     acc, rsp_due, gone, seen, drop;
        req_t   e;

        vecs[0] = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 32'hFFFF_0000, 0, 3'b001, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h8400_0004, 32'h0,         32'h0000_00A5, 0, 3'b010, 1'b0, 32'h0000_00A5};
        vecs[2] = '{1'b1, 32'h9000_0000, 32'h1234_5678, 32'hFFFF_0000, 0, 3'b000, 1'b1, 32'h0};
        vecs[3] = '{1'b0, 32'h83FF_FFFC, 32'h0,         32'h1234_5678, 0, 3'b001, 1'b0, 32'h1234_5678};
        vecs[4] = '{1'b1, 32'h87FF_FFFF, 32'h0BAD_F00D, 32'h5555_5555, 0, 3'b010, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h8800_0000, 32'h0,         32'hCAFE_F00D, 3, 3'b100, 1'b0, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 32'h8BFF_FFFF, 32'h0,         32'h600D_CAFE, 1, 3'b100, 1'b0, 32'h600D_CAFE};
        vecs[7] = '{1'b0, 32'h8C00_0000, 32'h0,         32'hAAAA_AAAA, 0, 3'b000, 1'b1, 32'h0};
        vecs[8] = '{1'b1, 32'h7FFF_FFFF, 32'h1111_1111, 32'h0,         0, 3'b000, 1'b1, 32'h0};
        vecs[9] = '{1'b0, 32'h0000_0000, 32'h0,         32'h7777_7777, 0, 3'b000, 1'b1, 32'h0};
        bnd = '{32'h7FFF_FFFF, 32'h8000_0000, 32'h83FF_FFFF, 32'h8400_0000,
                32'h87FF_FFFF, 32'h8800_0000, 32'h8BFF_FFFF, 32'h8C00_0000};
        bb_sel   = '{3'b000, 3'b100, 3'b100, 3'b001, 3'b001, 3'b000};
        bb_flags = '{3'b000, 3'b010, 3'b100, 3'b011, 3'b110, 3'b011};

        hresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        pready = 1'b1; prdata = '0;
        #12;
        check_reset_outputs("reset");
        @(negedge hclk); hresetn = 1'b1;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Back-to-back: second request is held until the buffer frees.
        tick();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8800_0000; req_wdata = 32'h1111_1111;
        tick();
        req_addr = 32'h8000_0000; req_wdata = 32'h2222_2222;
        for (int i = 0; i < 6; i++) begin
            smp();
            chk($sformatf("b2b/cyc%0d", i), 64'({pselx, penable, req_ready, rsp_valid}), 64'({bb_sel[i], bb_flags[i]}));
            if (i == 1) chk("b2b/setup_a", 64'({paddr, pwdata}), 64'({32'h8800_0000, 32'h1111_1111}));
            if (i == 3) chk("b2b/setup_b", 64'({paddr, pwdata}), 64'({32'h8000_0000, 32'h2222_2222}));
            if (i == 3 || i == 5) chk($sformatf("b2b/rsp%0d", i), 64'({rsp_err, rsp_rdata}), 64'(0));
            drop = req_valid && req_ready;
            tick();
            if (drop) req_valid = 1'b0;
        end

        // Timeout: pready never rises.
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h8000_0020; prdata = 32'hBEEF_0001; pready = 1'b0;
        tick(); req_valid = 1'b0;
        tick(); smp();
        chk("tmo/setup", 64'({pselx, penable}), 64'({3'b001, 1'b0}));
        cnt = 0; gone = 1'b0;
        for (int i = 0; i < 40 && !gone; i++) begin
            tick(); smp();
            if (penable) cnt++;
            else gone = 1'b1;
        end
        chk("tmo/access_cycles", 64'(cnt), 64'(16));
        chk("tmo/abort", 64'({pselx, penable, rsp_valid, rsp_err, rsp_rdata}), 64'({3'b000, 1'b0, 1'b1, 1'b1, 32'h0}));
        tick(); pready = 1'b1; smp();
        chk("tmo/after", 64'({rsp_valid, pselx, penable}), 64'(0));

        // Reset during ACCESS with a second request buffered.
        tick();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h8400_0100; req_wdata = 32'h4444_4444; pready = 1'b0;
        tick(); req_valid = 1'b0;
        tick();
        tick();
        req_valid = 1'b1; req_addr = 32'h8000_0000; req_wdata = 32'h5555_5555;
        smp(); chk("rst/pre_access", 64'({penable, req_ready}), 64'(2'b11));
        tick(); req_valid = 1'b0;
        smp(); chk("rst/pre_buffered", 64'({penable, req_ready}), 64'(2'b10));
        #2 hresetn = 1'b0;
        #1 check_reset_outputs("rst_mid");
        @(negedge hclk); hresetn = 1'b1; pready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            smp();
            if (rsp_valid || pselx != 3'b000 || penable) seen = 1'b1;
        end
        chk("rst/no_activity_after", 64'({seen, req_ready}), 64'(2'b01));

        // Randomized traffic checked against an in-order transaction model.
        n_sent = 0; zrun = 0; acc = 1'b0; rsp_due = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            if (n_sent >= NRAND && exp_q.size() == 0 && !req_valid) break;
            tick();
            if (acc) begin req_valid = 1'b0; acc = 1'b0; end
            if (!req_valid && n_sent < NRAND && $urandom_range(0, 2) != 0) begin
                req_valid = 1'b1; req_write = 1'($urandom_range(0, 1)); req_addr = rand_addr(); req_wdata = $urandom;
            end
            pready = (zrun >= 5) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            zrun   = pready ? 0 : zrun + 1;
            prdata = slave_rd(paddr);
            smp();
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rand/rsp_unexpected", 64'(rsp_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("rand/rsp", 64'({rsp_err, rsp_rdata}),
                        64'({ref_sel(e.addr) == 3'b000, (ref_sel(e.addr) != 3'b000 && !e.write) ? slave_rd(e.addr) : 32'h0}));
                    if (ref_sel(e.addr) != 3'b000) chk("rand/rsp_timing", 64'(rsp_due), 64'(1));
                end
            end else if (rsp_due) begin
                chk("rand/rsp_missing", 64'(rsp_valid), 64'(1));
            end
            rsp_due = penable && pready;
            if (pselx != 3'b000 && !penable) begin
                if (exp_q.size() == 0) begin
                    chk("rand/setup_unexpected", 64'(pselx), 64'(0));
                end else begin
                    chk("rand/setup", 64'({pselx, pwrite, paddr}), 64'({ref_sel(exp_q[0].addr), exp_q[0].write, exp_q[0].addr}));
                    if (exp_q[0].write) chk("rand/pwdata", 64'(pwdata), 64'(exp_q[0].wdata));
                end
            end
            if (req_valid && req_ready) begin
                exp_q.push_back('{req_write, req_addr, req_wdata});
                n_sent++;
                acc = 1'b1;
            end
        end
        chk("rand/drain", 64'(exp_q.size() + (req_valid ? 1 : 0)), 64'(0));
        chk("rand/sent", 64'(n_sent), 64'(NRAND));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
